debug_console_wb: RTL
=====================

DEBUG_CONSOLE_WB -- requirements
Module: debug_console_wb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning TX byte FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter NUM_CLASSES, default 5, meaning number of valid pass-class codes; 1..16.
REQ-003 SHALL have one clock and asynchronous active-high reset:
  wb_clk_i  in  1  clock, all state on rising edge
  wb_rst_i  in  1  asynchronous active-high reset
REQ-004 SHALL have Wishbone pipelined-slave ports:
  wb_cyc_i  in  1  bus cycle
  wb_stb_i  in  1  strobe
  wb_we_i  in  1  write enable
  wb_adr_i  in  32  byte address; [3:2] selects register
  wb_dat_i  in  32  write data
  wb_sel_i  in  4  byte selects
  wb_stall_o  out  1  constant 0
  wb_ack_o  out  1  access completed
  wb_dat_o  out  32  read data
  wb_err_o  out  1  access failed
REQ-005 SHALL have console stream and result ports:
  tx_data_o  out  8  FIFO head byte
  tx_valid_o  out  1  FIFO not empty
  tx_ready_i  in  1  sink accepts byte
  test_done_o  out  1  result code received (sticky)
  test_pass_o  out  1  result was a pass code
  test_code_o  out  8  last result code

Function
REQ-006 SHALL register map: 0x0 TXDATA (W push wb_dat_i[7:0]; R 0), 0x4 STATUS (R: [0] full, [1] empty, [2] overflow, [3] done, [4] pass, [15:8] level, [23:16] code), 0x8 RESULT (W code; R code), 0xC CTRL (W: [0] flush FIFO, [1] clear overflow; R 0).
REQ-007 SHALL accept request when wb_cyc_i & wb_stb_i; respond exactly one cycle later with single-cycle wb_ack_o or wb_err_o, never both.
REQ-008 SHALL accept back-to-back requests every cycle; wb_dat_o valid in the ack cycle, 0 otherwise.
REQ-009 SHALL push TXDATA write only when wb_sel_i[0]=1; sel[0]=0 acks with no push.
REQ-010 SHALL, on TXDATA write while full (evaluated before same-cycle pop), drop byte, set sticky overflow, respond wb_err_o.
REQ-011 SHALL pop when tx_valid_o & tx_ready_i; simultaneous push and pop on non-full FIFO leaves level unchanged.
REQ-012 SHALL wrap read/write pointers modulo FIFO_DEPTH; level counter width clog2(FIFO_DEPTH)+1.
REQ-013 SHALL, on CTRL[0] write, empty FIFO at the response edge; flush overrides same-cycle push and pop.
REQ-014 SHALL, on RESULT write, store wb_dat_i[7:0] into test_code_o, set test_done_o.
REQ-015 SHALL set test_pass_o when code[3:0]=0xF and code[7:4]<NUM_CLASSES; 0xFF is fail; 0x90 is halt (done, pass=0); any other code is fail.
REQ-016 SHALL let later RESULT writes overwrite code and pass; done stays 1 until reset.
REQ-017 SHALL respond wb_err_o to writes of read-only bits' registers? No: writes to STATUS and any address with wb_adr_i[31:4] nonzero SHALL respond wb_err_o with no side effect.

Reset
REQ-018 SHALL, on wb_rst_i, asynchronously clear: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, tx_valid_o=0, tx_data_o=0, test_done_o=0, test_pass_o=0, test_code_o=0, overflow=0, pointers/level=0.
REQ-019 SHALL drop any in-flight request when reset asserts mid-access; no ack after release for it.

Configuration
REQ-020 SHALL, with DEBUG_CONSOLE_SIM_EN defined, $write each popped byte as a character, $display time and class/result on RESULT write, and $finish on any RESULT write.
REQ-021 SHALL, without DEBUG_CONSOLE_SIM_EN, contain no simulation-only constructs; behaviour otherwise identical.

Structure
REQ-022 SHALL place register offsets, STATUS bit indices, pass nibble 0xF, FAIL 0xFF, HALT 0x90 in package debug_console_pkg.
REQ-023 SHALL implement the FIFO as sub-module debug_console_fifo (push, pop, flush, full, empty, level).

Verification
REQ-024 Write 0x48,0x69 to 0x0, tx_ready_i=1 -> acks next cycle; tx_data_o 0x48 then 0x69; empty after.
REQ-025 tx_ready_i=0, 17 writes with FIFO_DEPTH=16 -> 16 acks, 17th wb_err_o; STATUS=full, overflow, level 16.
REQ-026 Write 0x2F to 0x8 -> test_done_o=1, test_pass_o=1, test_code_o=0x2F; then 0x5F (NUM_CLASSES=5) -> pass=0.
REQ-027 Write 0xFF to 0x8 -> done=1, pass=0; read 0x4 -> [23:16]=0xFF, bit3=1, bit4=0.
REQ-028 FIFO level 8, CTRL=1 written with tx_ready_i=1 -> level 0, tx_valid_o=0 next cycle.
REQ-029 Reset asserted during pending TXDATA write, level 5 -> no ack, all outputs 0, level 0.

Source files
------------

// File: rtl/debug_console_pkg.sv
// ============================================================================
// Module   : debug_console_pkg
// Brief    : Register map, STATUS bit positions and result-code constants
//            shared by the debug console slave and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_console_pkg;

    // Register index taken from wb_adr_i[3:2]
    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_RESULT = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_DONE      = 3;
    localparam int STAT_PASS      = 4;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_CODE_LSB  = 16;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_OVF   = 1;

    localparam logic [3:0] PASS_NIBBLE = 4'hF;
    localparam logic [7:0] CODE_FAIL   = 8'hFF;
    localparam logic [7:0] CODE_HALT   = 8'h90;

    // 0xFF carries the pass nibble but is reserved as the explicit fail code
    function automatic logic code_is_pass(input logic [7:0] code, input int num_classes);
        return (code != CODE_FAIL) && (code[3:0] == PASS_NIBBLE) &&
               (int'(code[7:4]) < num_classes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_console_fifo.sv
// ============================================================================
// Module   : debug_console_fifo
// Brief    : Byte FIFO for console output; flush overrides push and pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_console_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               head
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/debug_console_wb.sv
// ============================================================================
// Module   : debug_console_wb
// Brief    : Wishbone pipelined debug console: TX byte FIFO plus test-result
//            register. Define DEBUG_CONSOLE_SIM_EN for simulation printing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_console_wb
    import debug_console_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int NUM_CLASSES = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        test_done_o,
    output logic        test_pass_o,
    output logic [7:0]  test_code_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e    rsel;
    logic        req;
    logic        wr;
    logic        addr_ok;
    logic        full;
    logic        empty;
    logic [LW-1:0] level;
    logic        push;
    logic        pop;
    logic        flush;
    logic        clr_ovf;
    logic        ovf_set;
    logic        res_wr;
    logic        resp_err;
    logic        overflow;
    logic [31:0] status_word;
    logic [31:0] rdata;
    logic        unused_bits;

    assign wb_stall_o = 1'b0;
    assign rsel       = reg_sel_e'(wb_adr_i[3:2]);
    assign req        = wb_cyc_i & wb_stb_i;
    assign wr         = req & wb_we_i;
    assign addr_ok    = ~|wb_adr_i[31:4];
    assign unused_bits = ^{wb_dat_i[31:8], wb_sel_i[3:1], wb_adr_i[1:0]};

    // Full is judged before any same-cycle pop, so a write into a full FIFO errs
    assign ovf_set  = wr & addr_ok & (rsel == REG_TXDATA) & wb_sel_i[0] & full;
    assign resp_err = wr & (~addr_ok | (rsel == REG_STATUS) | ovf_set);
    assign push     = wr & addr_ok & (rsel == REG_TXDATA) & wb_sel_i[0] & ~full;
    assign flush    = wr & addr_ok & (rsel == REG_CTRL) & wb_dat_i[CTRL_FLUSH];
    assign clr_ovf  = wr & addr_ok & (rsel == REG_CTRL) & wb_dat_i[CTRL_CLR_OVF];
    assign res_wr   = wr & addr_ok & (rsel == REG_RESULT);
    assign pop      = tx_valid_o & tx_ready_i;
    assign tx_valid_o = ~empty;

    debug_console_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (wb_dat_i[7:0]),
        .pop       (pop),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head      (tx_data_o)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]     = full;
        status_word[STAT_EMPTY]    = empty;
        status_word[STAT_OVERFLOW] = overflow;
        status_word[STAT_DONE]     = test_done_o;
        status_word[STAT_PASS]     = test_pass_o;
        status_word[STAT_LEVEL_LSB +: 8] = 8'(level);
        status_word[STAT_CODE_LSB +: 8]  = test_code_o;
    end

    always_comb begin
        rdata = '0;
        if (req && !wb_we_i && addr_ok) begin
            case (rsel)
                REG_STATUS: rdata = status_word;
                REG_RESULT: rdata = {24'h0, test_code_o};
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            overflow    <= 1'b0;
            test_done_o <= 1'b0;
            test_pass_o <= 1'b0;
            test_code_o <= '0;
        end else begin
            wb_ack_o <= req & ~resp_err;
            wb_err_o <= resp_err;
            wb_dat_o <= rdata;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
            if (res_wr) begin
                test_code_o <= wb_dat_i[7:0];
                test_done_o <= 1'b1;
                test_pass_o <= code_is_pass(wb_dat_i[7:0], NUM_CLASSES);
            end
        end
    end

`ifdef DEBUG_CONSOLE_SIM_EN
    always @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (pop) $write("%c", tx_data_o);
            if (res_wr) begin
                $display("[%0t] debug_console: class %0d code 0x%02h (%s)", $time,
                         wb_dat_i[7:4], wb_dat_i[7:0],
                         wb_dat_i[7:0] == CODE_HALT ? "halt" :
                         code_is_pass(wb_dat_i[7:0], NUM_CLASSES) ? "pass" : "fail");
                $finish;
            end
        end
    end
`endif

endmodule

`default_nettype wire
